// File: rtl/n64_joybus_tx.sv
// Joybus bit-cell transmitter: serialises reply bytes MSB first as pulse-width cells
// on the open-drain console line, ending with the controller stop bit. Optional guard: JOYBUS_TX_GUARD_EN.
module n64_joybus_tx #(
    parameter int CLKS_PER_QUARTER = 4
`ifdef JOYBUS_TX_GUARD_EN
    ,
    parameter int GUARD_QUARTERS = 2
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       line_oe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    localparam int QW = $clog2(CLKS_PER_QUARTER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_STOP
    } state_t;

    state_t        state_q;
    logic [QW-1:0] qcnt_q;
    logic [1:0]    qidx_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          last_q;
    logic [7:0]    pend_data_q;
    logic          pend_last_q;
    logic          pend_valid_q;
    logic          under_q;
    logic          line_oe_q;
    logic          busy_q;
    logic          done_q;
    logic          underrun_q;
`ifdef JOYBUS_TX_GUARD_EN
    localparam int GW = (GUARD_QUARTERS > 1) ? $clog2(GUARD_QUARTERS) : 1;
    logic [GW-1:0] guard_cnt_q;
`endif

    logic q_wrap_d;
    logic fetch_win_d;
    logic accept_d;
    logic low_end_d;
    logic cell_end_d;

    // Handshake: a byte is taken on every cycle with tx_valid & tx_ready. tx_ready is high
    // in IDLE and for the whole final quarter of a non-last byte's LSB; a second handshake
    // inside that quarter replaces the pending byte, so a source offers one byte per window.
    assign q_wrap_d    = (qcnt_q == QW'(CLKS_PER_QUARTER - 1));
    assign fetch_win_d = (state_q == S_BIT_HIGH) && (qidx_q == 2'd3) &&
                         (bit_cnt_q == 3'd7) && !last_q;
    assign tx_ready    = (state_q == S_IDLE) || fetch_win_d;
    assign accept_d    = tx_valid && tx_ready;
    // qidx counts quarters within the 4-quarter cell; a 1 ends its low phase after quarter 0.
    assign low_end_d   = q_wrap_d && (qidx_q == (shift_q[7] ? 2'd0 : 2'd2));
    assign cell_end_d  = q_wrap_d && (qidx_q == 2'd3);

    assign line_oe  = line_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            qcnt_q       <= '0;
            qidx_q       <= 2'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            last_q       <= 1'b0;
            pend_data_q  <= 8'd0;
            pend_last_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            under_q      <= 1'b0;
            line_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
`ifdef JOYBUS_TX_GUARD_EN
            guard_cnt_q  <= '0;
`endif
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            if (state_q != S_IDLE) begin
                qcnt_q <= q_wrap_d ? '0 : qcnt_q + 1'b1;
                if (q_wrap_d) begin
                    qidx_q <= qidx_q + 2'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        shift_q      <= tx_data;
                        last_q       <= tx_last;
                        busy_q       <= 1'b1;
                        bit_cnt_q    <= 3'd0;
                        qcnt_q       <= '0;
                        qidx_q       <= 2'd0;
                        pend_valid_q <= 1'b0;
                        under_q      <= 1'b0;
`ifdef JOYBUS_TX_GUARD_EN
                        guard_cnt_q  <= '0;
                        state_q      <= S_GUARD;
`else
                        line_oe_q    <= 1'b1;
                        state_q      <= S_BIT_LOW;
`endif
                    end
                end
`ifdef JOYBUS_TX_GUARD_EN
                S_GUARD: begin
                    if (q_wrap_d) begin
                        if (guard_cnt_q == GW'(GUARD_QUARTERS - 1)) begin
                            qidx_q    <= 2'd0;
                            line_oe_q <= 1'b1;
                            state_q   <= S_BIT_LOW;
                        end else begin
                            guard_cnt_q <= guard_cnt_q + 1'b1;
                        end
                    end
                end
`endif
                S_BIT_LOW: begin
                    if (low_end_d) begin
                        line_oe_q <= 1'b0;
                        state_q   <= S_BIT_HIGH;
                    end
                end
                S_BIT_HIGH: begin
                    if (accept_d && !cell_end_d) begin
                        pend_data_q  <= tx_data;
                        pend_last_q  <= tx_last;
                        pend_valid_q <= 1'b1;
                    end
                    if (cell_end_d) begin
                        // Every cell exit starts a low phase: next bit, next byte or stop bit.
                        line_oe_q <= 1'b1;
                        if (bit_cnt_q != 3'd7) begin
                            shift_q   <= {shift_q[6:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            state_q   <= S_BIT_LOW;
                        end else if (last_q) begin
                            state_q <= S_STOP;
                        end else if (accept_d) begin
                            shift_q      <= tx_data;
                            last_q       <= tx_last;
                            bit_cnt_q    <= 3'd0;
                            pend_valid_q <= 1'b0;
                            state_q      <= S_BIT_LOW;
                        end else if (pend_valid_q) begin
                            shift_q      <= pend_data_q;
                            last_q       <= pend_last_q;
                            bit_cnt_q    <= 3'd0;
                            pend_valid_q <= 1'b0;
                            state_q      <= S_BIT_LOW;
                        end else begin
                            under_q <= 1'b1;
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (q_wrap_d && (qidx_q == 2'd1)) begin
                        qidx_q     <= 2'd0;
                        line_oe_q  <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= !under_q;
                        underrun_q <= under_q;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    line_oe_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_n64_joybus_tx.sv
// Bench for n64_joybus_tx: random frames against a cell-level waveform model, with
// a scoreboard queue of expected line runs and frame endings checked by a monitor.
module tb_n64_joybus_tx;
    localparam int CPQ   = 4;
    localparam int GQ    = 2;
    localparam int LIMIT = 400;
`ifdef JOYBUS_TX_GUARD_EN
    localparam int GUARD_CYC = GQ * CPQ;
`else
    localparam int GUARD_CYC = 0;
`endif
    localparam int K_LOW   = 0;
    localparam int K_REL   = 1;
    localparam int K_DONE  = 2;
    localparam int K_UNDER = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       line_oe;
    logic       busy;
    logic       done;
    logic       underrun;

    n64_joybus_tx #(
        .CLKS_PER_QUARTER(CPQ)
`ifdef JOYBUS_TX_GUARD_EN
        ,
        .GUARD_QUARTERS(GQ)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .line_oe  (line_oe),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // item = {kind[1:0], aux[13:0], len[15:0]}; runs: K_LOW (line pulled) / K_REL (released),
    // endings: K_DONE / K_UNDER with aux = tx_ready cycles and len = busy cycles.
    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          frame_len;
    int          frame_ready;
    int          first_acc;
    bit          abort;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input int kind, input int aux, input int len);
        return {2'(kind), 14'(aux), 16'(len)};
    endfunction

    // Reference model: each bit is a 4-quarter cell, a 1 is low for one quarter and a 0
    // for three; the frame closes with a two-quarter low stop bit.
    task automatic model_start();
        frame_len   = 0;
        frame_ready = 0;
        if (GUARD_CYC > 0) begin
            exp_q.push_back(mk(K_REL, 0, GUARD_CYC));
            frame_len += GUARD_CYC;
        end
    endtask

    task automatic model_byte(input logic [7:0] d, input bit last);
        int lo;
        for (int i = 7; i >= 0; i--) begin
            lo = d[i] ? CPQ : 3 * CPQ;
            exp_q.push_back(mk(K_LOW, 0, lo));
            exp_q.push_back(mk(K_REL, 0, 4 * CPQ - lo));
            frame_len += 4 * CPQ;
        end
        if (!last) frame_ready += CPQ;
    endtask

    task automatic model_end(input bit under);
        exp_q.push_back(mk(K_LOW, 0, 2 * CPQ));
        frame_len += 2 * CPQ;
        exp_q.push_back(mk(under ? K_UNDER : K_DONE, frame_ready, frame_len));
    endtask

    // ---------------- driver tasks ----------------
    task automatic put_byte(input logic [7:0] d, input bit last, input int dly,
                            input bit first, output bit ok);
        int t;
        ok = 1'b0;
        t  = 0;
        while (!tx_ready && !abort && t < LIMIT) begin
            @(posedge clk); #1;
            t++;
        end
        if (abort) return;
        if (!tx_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
        end
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        check("ready_at_offer", int'(tx_ready), 1);
        if (first) begin
            model_start();
            first_acc = cyc;
            acc_q.push_back(cyc);
        end
        model_byte(d, last);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        tx_last  = 1'($urandom);
        t = 0;
        while (tx_ready && t < CPQ + 1) begin
            @(posedge clk); #1;
            t++;
        end
        ok = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b [4], input int n, input bit under,
                              input int maxdly);
        bit ok;
        bit last;
        int dly;
        int t;
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1) && !under;
            dly  = (k == 0) ? 0 : int'($urandom_range(0, maxdly));
            put_byte(b[k], last, dly, k == 0, ok);
            if (!ok) return;
        end
        model_end(under);
        if (under) begin
            t = 0;
            while (!tx_ready && t < LIMIT) begin
                @(posedge clk); #1;
                t++;
            end
            check("underrun_window_seen", int'(tx_ready), 1);
            t = 0;
            while (tx_ready && t < CPQ + 1) begin
                @(posedge clk); #1;
                t++;
            end
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            tx_last  = 1'b1;
            for (int i = 0; i < CPQ; i++) begin
                check("ready_low_after_underrun", int'(tx_ready), 0);
                @(posedge clk); #1;
            end
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("frame_ends", int'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_ready"}, int'(tx_ready), 1);
        check({tag, "_line_oe"}, int'(line_oe), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
    endtask

    // ---------------- monitor ----------------
    bit          in_frame = 1'b0;
    int          run_val;
    int          run_len;
    int          busy_len;
    int          ready_cnt;
    logic [31:0] end_item;

    task automatic close_run();
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check("run_unexpected", run_len, 0);
            return;
        end
        e = exp_q.pop_front();
        check("run_kind", run_val ? K_LOW : K_REL, int'(e[31:30]));
        check("run_len", run_len, int'(e[15:0]));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else if (busy) begin
            if (!in_frame) begin
                in_frame  = 1'b1;
                run_val   = int'(line_oe);
                run_len   = 1;
                busy_len  = 1;
                ready_cnt = int'(tx_ready);
                if (acc_q.size() == 0) check("start_without_accept", 1, 0);
                else check("start_latency", cyc - acc_q.pop_front(), 1);
            end else begin
                busy_len++;
                ready_cnt += int'(tx_ready);
                if (int'(line_oe) == run_val) begin
                    run_len++;
                end else begin
                    close_run();
                    run_val = int'(line_oe);
                    run_len = 1;
                end
            end
            if (done || underrun) check("pulse_while_busy", int'({done, underrun}), 0);
        end else if (in_frame) begin
            close_run();
            in_frame = 1'b0;
            check("release_at_end", int'(line_oe), 0);
            if (exp_q.size() == 0) begin
                check("end_unexpected", 1, 0);
            end else begin
                end_item = exp_q.pop_front();
                check("end_done", int'(done), int'(end_item[31:30] == 2'(K_DONE)));
                check("end_underrun", int'(underrun), int'(end_item[31:30] == 2'(K_UNDER)));
                check("busy_cycles", busy_len, int'(end_item[15:0]));
                check("ready_cycles", ready_cnt, int'(end_item[29:16]));
            end
        end else if (done || underrun || line_oe) begin
            check("idle_outputs", int'({done, underrun, line_oe}), 0);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] fb [4];
    int         n;
    bit         under;

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        tx_last  = 1'b0;
        abort    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fb = '{8'h80, 8'h00, 8'h00, 8'h00};
        send_frame(fb, 1, 1'b0, 0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        fb = '{8'h05, 8'h00, 8'h02, 8'h00};
        send_frame(fb, 4, 1'b0, 0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        fb = '{8'hFF, 8'h00, 8'h00, 8'h00};
        send_frame(fb, 1, 1'b1, 0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        // back-to-back: the second frame is offered in the cycle done pulses
        fb = '{8'h80, 8'h00, 8'h00, 8'h00};
        send_frame(fb, 1, 1'b0, 0);
        wait_idle();
        check("b2b_done_visible", int'(done), 1);
        fb = '{8'h01, 8'h00, 8'h00, 8'h00};
        send_frame(fb, 1, 1'b0, 0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        // reset in the low phase of byte 2, bit 3 of an INFO reply
        fb = '{8'h05, 8'h00, 8'h02, 8'h00};
        fork
            send_frame(fb, 4, 1'b0, 0);
            begin
                @(posedge clk); #2;
                while (cyc < first_acc + 1 + GUARD_CYC + 2 * 32 * CPQ + 4 * 4 * CPQ + 5) begin
                    @(posedge clk); #2;
                end
                check("pre_reset_low", int'(line_oe), 1);
                abort = 1'b1;
                reset = 1'b1;
                exp_q.delete();
                acc_q.delete();
                #1;
                check("reset_releases_line", int'(line_oe), 0);
                check_reset_outputs("mid");
                repeat (3) @(posedge clk);
                #1;
                reset = 1'b0;
            end
        join
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fb = '{8'h80, 8'h00, 8'h00, 8'h00};
        send_frame(fb, 1, 1'b0, 0);
        wait_idle();

        for (int f = 0; f < 10; f++) begin
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) fb[k] = 8'($urandom);
            under = ($urandom_range(0, 3) == 0);
            send_frame(fb, n, under, CPQ - 1);
            wait_idle();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
            end
        end

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
